flsh_cfg_req_seq: RTL and testbench

Request sequencer that sits directly upstream of the flash/VPD wrapper's flash port. It accepts single register read/write requests from the host-interface MMIO decode over a valid/ready channel and drives the `cfg_flsh_*` hold-until-done handshake. It captures `flsh_cfg_rdata` and the responses, and returns one response per request over a valid/ready channel. It also provides an optional watchdog so a hung AXI4-Lite target cannot stall the host interface.

---
 rtl/flsh_cfg_req_seq.sv | 190 +++++++++++++++++++
 tb/tb_flsh_cfg_req_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flsh_cfg_req_seq.sv
// Single-outstanding request sequencer in front of the flash/VPD port: host valid/ready in, hold-until-done strobe out.
// Optional watchdog on a stuck strobe is built when FLSH_REQ_SEQ_TIMEOUT_EN is defined.
module flsh_cfg_req_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clock_afu,
    input  logic        reset_afu,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_devsel,
    input  logic [13:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_expand_enable,
    input  logic        req_expand_dir,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [1:0]  cfg_flsh_devsel,
    output logic [13:0] cfg_flsh_addr,
    output logic        cfg_flsh_wren,
    output logic [31:0] cfg_flsh_wdata,
    output logic        cfg_flsh_rden,
    output logic        cfg_flsh_expand_enable,
    output logic        cfg_flsh_expand_dir,
    input  logic [31:0] flsh_cfg_rdata,
    input  logic        flsh_cfg_done,
    input  logic [1:0]  flsh_cfg_bresp,
    input  logic [1:0]  flsh_cfg_rresp,
    output logic        stray_done
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("flsh_cfg_req_seq: TIMEOUT_CYCLES must be 2..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_done;
    logic        w_tmo;
    logic        w_tmo_expired;

    logic [1:0]  r_devsel;
    logic [13:0] r_addr;
    logic        r_wren;
    logic        r_rden;
    logic [31:0] r_wdata;
    logic        r_expand_enable;
    logic        r_expand_dir;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;
    logic        r_stray_done;

`ifdef FLSH_REQ_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tmo_cnt;
    logic        r_rsp_timeout;

    // Held at zero outside ISSUE, so every command starts counting from 0.
    always_ff @(posedge clock_afu or posedge reset_afu) begin
        if (reset_afu)
            r_tmo_cnt <= '0;
        else if (r_state != ST_ISSUE)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end

    assign w_tmo_expired = (r_state == ST_ISSUE) && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clock_afu or posedge reset_afu) begin
        if (reset_afu)
            r_rsp_timeout <= 1'b0;
        else if (w_done)
            r_rsp_timeout <= 1'b0;
        else if (w_tmo)
            r_rsp_timeout <= 1'b1;
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_tmo_expired = 1'b0;
    assign rsp_timeout   = 1'b0;
`endif

    always_ff @(posedge clock_afu or posedge reset_afu) begin
        if (reset_afu)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Done takes priority over an expiring watchdog on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (flsh_cfg_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_tmo_expired) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_afu or posedge reset_afu) begin
        if (reset_afu) begin
            r_devsel        <= '0;
            r_addr          <= '0;
            r_wren          <= 1'b0;
            r_rden          <= 1'b0;
            r_wdata         <= '0;
            r_expand_enable <= 1'b0;
            r_expand_dir    <= 1'b0;
        end else if (w_accept) begin
            r_devsel        <= req_devsel;
            r_addr          <= req_addr;
            r_wren          <= req_write;
            r_rden          <= ~req_write;
            r_wdata         <= req_wdata;
            r_expand_enable <= req_expand_enable;
            r_expand_dir    <= req_expand_dir;
        end else if (w_done || w_tmo) begin
            r_wren          <= 1'b0;
            r_rden          <= 1'b0;
        end
    end

    // r_wren is still the command type on the edge that ends ISSUE.
    always_ff @(posedge clock_afu or posedge reset_afu) begin
        if (reset_afu) begin
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else if (w_done) begin
            r_rsp_rdata <= r_wren ? 32'd0 : flsh_cfg_rdata;
            r_rsp_resp  <= r_wren ? flsh_cfg_bresp : flsh_cfg_rresp;
        end else if (w_tmo) begin
            r_rsp_rdata <= 32'hFFFF_FFFF;
            r_rsp_resp  <= 2'b10;
        end
    end

    always_ff @(posedge clock_afu or posedge reset_afu) begin
        if (reset_afu)
            r_stray_done <= 1'b0;
        else if (flsh_cfg_done && (r_state != ST_ISSUE))
            r_stray_done <= 1'b1;
    end

    assign req_ready              = (r_state == ST_IDLE);
    assign rsp_valid              = (r_state == ST_RESP);
    assign rsp_rdata              = r_rsp_rdata;
    assign rsp_resp               = r_rsp_resp;
    assign cfg_flsh_devsel        = r_devsel;
    assign cfg_flsh_addr          = r_addr;
    assign cfg_flsh_wren          = r_wren;
    assign cfg_flsh_wdata         = r_wdata;
    assign cfg_flsh_rden          = r_rden;
    assign cfg_flsh_expand_enable = r_expand_enable;
    assign cfg_flsh_expand_dir    = r_expand_dir;
    assign stray_done             = r_stray_done;

endmodule

// File: tb/tb_flsh_cfg_req_seq.sv
// Scoreboard bench for flsh_cfg_req_seq: driver pushes expected strobes/responses, monitors pop and compare.
// Watchdog scenarios are included when FLSH_REQ_SEQ_TIMEOUT_EN is defined.
module tb_flsh_cfg_req_seq;
    localparam int TMO = 8;
`ifdef FLSH_REQ_SEQ_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    typedef struct {
        bit          write;
        logic [1:0]  devsel;
        logic [13:0] addr;
        logic [31:0] wdata;
        bit          en;
        bit          dir;
        int          delay;
        logic [31:0] rdata;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        int          nstrobe;
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        bit          tmo;
    } rsp_t;

    logic        clock_afu = 1'b0;
    logic        reset_afu = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_devsel = '0;
    logic [13:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_expand_enable = 1'b0;
    logic        req_expand_dir = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [1:0]  cfg_flsh_devsel;
    logic [13:0] cfg_flsh_addr;
    logic        cfg_flsh_wren;
    logic [31:0] cfg_flsh_wdata;
    logic        cfg_flsh_rden;
    logic        cfg_flsh_expand_enable;
    logic        cfg_flsh_expand_dir;
    logic [31:0] flsh_cfg_rdata = '0;
    logic        flsh_cfg_done;
    logic [1:0]  flsh_cfg_bresp = '0;
    logic [1:0]  flsh_cfg_rresp = '0;
    logic        stray_done;

    logic fl_done  = 1'b0;
    logic inj_done = 1'b0;
    bit   rr_force = 1'b0;
    bit   rr_val   = 1'b0;
    assign flsh_cfg_done = fl_done | inj_done;

    logic [89:0] outvec;
    assign outvec = {req_ready, cfg_flsh_devsel, cfg_flsh_addr, cfg_flsh_wren, cfg_flsh_wdata,
                     cfg_flsh_rden, cfg_flsh_expand_enable, cfg_flsh_expand_dir, rsp_valid,
                     rsp_rdata, rsp_resp, rsp_timeout, stray_done};
    localparam logic [89:0] RESET_VEC = {1'b1, 89'd0};

    cmd_t cmd_q[$];
    cmd_t fl_q[$];
    rsp_t rsp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    flsh_cfg_req_seq #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock_afu(clock_afu), .reset_afu(reset_afu),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_devsel(req_devsel), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_expand_enable(req_expand_enable), .req_expand_dir(req_expand_dir),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .cfg_flsh_devsel(cfg_flsh_devsel), .cfg_flsh_addr(cfg_flsh_addr),
        .cfg_flsh_wren(cfg_flsh_wren), .cfg_flsh_wdata(cfg_flsh_wdata),
        .cfg_flsh_rden(cfg_flsh_rden), .cfg_flsh_expand_enable(cfg_flsh_expand_enable),
        .cfg_flsh_expand_dir(cfg_flsh_expand_dir),
        .flsh_cfg_rdata(flsh_cfg_rdata), .flsh_cfg_done(flsh_cfg_done),
        .flsh_cfg_bresp(flsh_cfg_bresp), .flsh_cfg_rresp(flsh_cfg_rresp),
        .stray_done(stray_done)
    );

    initial forever #5 clock_afu = ~clock_afu;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference: a done inside the watchdog window returns the target's answer, otherwise the abort pattern.
    function automatic rsp_t model(input cmd_t c);
        rsp_t r;
        if (TMO_ON && c.delay > TMO) begin
            r.rdata = 32'hFFFF_FFFF;
            r.resp  = 2'b10;
            r.tmo   = 1'b1;
        end else begin
            r.rdata = c.write ? 32'd0 : c.rdata;
            r.resp  = c.write ? c.bresp : c.rresp;
            r.tmo   = 1'b0;
        end
        return r;
    endfunction

    function automatic int strobe_len(input cmd_t c);
        return (TMO_ON && c.delay > TMO) ? TMO : c.delay;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.write   = bit'($urandom_range(0, 1));
        c.devsel  = 2'($urandom_range(0, 3));
        c.addr    = 14'($urandom);
        c.wdata   = $urandom;
        c.en      = bit'($urandom_range(0, 1));
        c.dir     = bit'($urandom_range(0, 1));
        c.delay   = $urandom_range(1, 12);
        c.rdata   = $urandom;
        c.bresp   = 2'($urandom_range(0, 3));
        c.rresp   = 2'($urandom_range(0, 3));
        c.nstrobe = 0;
        return c;
    endfunction

    task automatic push_req(input cmd_t c, input bit expect_rsp);
        cmd_q.push_back(c);
        fl_q.push_back(c);
        if (expect_rsp) rsp_q.push_back(model(c));
        @(posedge clock_afu);
        #1;
        req_valid         = 1'b1;
        req_write         = c.write;
        req_devsel        = c.devsel;
        req_addr          = c.addr;
        req_wdata         = c.wdata;
        req_expand_enable = c.en;
        req_expand_dir    = c.dir;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock_afu);
            if (req_ready) begin
                @(posedge clock_afu);
                #1;
                req_valid = 1'b0;
                return;
            end
        end
        fail_bound("accept");
        req_valid = 1'b0;
    endtask

    task automatic do_req(input cmd_t c);
        c.nstrobe = strobe_len(c);
        push_req(c, 1'b1);
        wait_accept();
    endtask

    // Flash target: raises done during the delay-th strobe-high cycle of each command.
    cmd_t fcur;
    int   fcnt = 0;
    initial forever begin
        @(negedge clock_afu);
        if (cfg_flsh_wren || cfg_flsh_rden) begin
            if (fcnt == 0) begin
                if (fl_q.size() > 0) fcur = fl_q.pop_front();
                else fcur.delay = 0;
            end
            fcnt++;
            fl_done        = (fcnt == fcur.delay);
            flsh_cfg_rdata = fcur.rdata;
            flsh_cfg_bresp = fcur.bresp;
            flsh_cfg_rresp = fcur.rresp;
        end else begin
            fcnt           = 0;
            fl_done        = 1'b0;
            flsh_cfg_rdata = $urandom;
            flsh_cfg_bresp = 2'($urandom_range(0, 3));
            flsh_cfg_rresp = 2'($urandom_range(0, 3));
        end
    end

    initial forever begin
        @(posedge clock_afu);
        #1;
        rsp_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
    end

    // Monitors: response handshakes and strobe windows.
    cmd_t mcur;
    rsp_t mexp;
    int   scnt = 0;
    bit   sok = 1'b1;
    initial forever begin
        @(negedge clock_afu);
        if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                fail_bound("rsp_unexpected");
            end else begin
                mexp = rsp_q.pop_front();
                check("rsp", {rsp_rdata, rsp_resp, rsp_timeout}, {mexp.rdata, mexp.resp, mexp.tmo});
            end
        end
        if (cfg_flsh_wren || cfg_flsh_rden) begin
            if (scnt == 0) begin
                if (cmd_q.size() == 0) fail_bound("strobe_unexpected");
                else mcur = cmd_q.pop_front();
            end
            sok &= ({cfg_flsh_wren, cfg_flsh_rden, cfg_flsh_devsel, cfg_flsh_addr, cfg_flsh_wdata,
                     cfg_flsh_expand_enable, cfg_flsh_expand_dir} ===
                    {mcur.write, !mcur.write, mcur.devsel, mcur.addr, mcur.wdata, mcur.en, mcur.dir});
            scnt++;
        end else if (scnt != 0) begin
            check("strobe_len", scnt, mcur.nstrobe);
            check("cmd_stable", sok, 1);
            check("rsp_after_done", rsp_valid, !reset_afu);
            scnt = 0;
            sok  = 1'b1;
        end
    end

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (rsp_q.size() == 0 && cmd_q.size() == 0 && scnt == 0) return;
            @(negedge clock_afu);
        end
        fail_bound("drain");
    endtask

    task automatic pulse_done();
        @(posedge clock_afu);
        #1;
        inj_done = 1'b1;
        @(posedge clock_afu);
        #1;
        inj_done = 1'b0;
        @(negedge clock_afu);
    endtask

    cmd_t        c;
    logic [34:0] snap;
    bit          bp_ok;
    int          n;
    bit          seen;

    initial begin
        #1 reset_afu = 1'b1;
        #2 check("reset_state", outvec, RESET_VEC);
        @(negedge clock_afu);
        reset_afu = 1'b0;

        c = rand_cmd();
        c.write = 1'b0; c.devsel = 2'd1; c.addr = 14'h0010; c.delay = 5;
        c.rdata = 32'hA5A5_1234; c.rresp = 2'b00; c.bresp = 2'b11;
        do_req(c);

        c = rand_cmd();
        c.write = 1'b1; c.wdata = 32'hCAFE_F00D; c.delay = 4; c.bresp = 2'b10; c.rresp = 2'b01;
        do_req(c);
        drain();

        // Backpressure: response held, second request waiting.
        rr_force = 1'b1;
        rr_val   = 1'b0;
        c = rand_cmd();
        c.delay = 3;
        do_req(c);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock_afu);
            seen = rsp_valid;
        end
        if (!seen) fail_bound("bp_rsp_valid");
        c = rand_cmd();
        c.delay = 2;
        c.nstrobe = strobe_len(c);
        push_req(c, 1'b1);
        snap  = {rsp_rdata, rsp_resp, rsp_timeout};
        bp_ok = 1'b1;
        repeat (10) begin
            @(negedge clock_afu);
            bp_ok &= !req_ready && rsp_valid && (snap === {rsp_rdata, rsp_resp, rsp_timeout});
        end
        check("bp_hold", bp_ok, 1);
        @(posedge clock_afu);
        rr_val = 1'b1;
        for (n = 1; n <= 10; n++) begin
            @(posedge clock_afu);
            @(negedge clock_afu);
            if (cfg_flsh_wren || cfg_flsh_rden) break;
        end
        check("bp_restart", n, 2);
        req_valid = 1'b0;
        rr_force  = 1'b0;
        drain();

        repeat (30) do_req(rand_cmd());
        drain();
        check("stray_idle", stray_done, 0);

`ifdef FLSH_REQ_SEQ_TIMEOUT_EN
        c = rand_cmd();
        c.delay = 1000;
        do_req(c);
        drain();
        pulse_done();
        check("stray_after_timeout", stray_done, 1);

        c = rand_cmd();
        c.delay = TMO;
        do_req(c);
        drain();
`endif

        // Reset during ISSUE.
        c = rand_cmd();
        c.delay = 1000;
        c.nstrobe = 3;
        push_req(c, 1'b0);
        wait_accept();
        repeat (3) @(negedge clock_afu);
        #2 reset_afu = 1'b1;
        #1 check("reset_mid_issue", outvec, RESET_VEC);
        repeat (2) @(posedge clock_afu);
        #2 reset_afu = 1'b0;
        pulse_done();
        check("stray_late_done", stray_done, 1);

        c = rand_cmd();
        c.delay = 3;
        do_req(c);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
